// File: rtl/cordic_client_pkg.sv
// cordic_client_pkg
// Shared definitions for the CORDIC requester-side handshake controller:
// FSM state encoding, op codes and the default data width.
package cordic_client_pkg;

    localparam int W_DEFAULT = 32;

    localparam logic OP_COS = 1'b0;
    localparam logic OP_SIN = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_ACK   = 2'd3
    } state_e;

endpackage

// File: rtl/cordic_wdt_counter.sv
// cordic_wdt_counter
// Watchdog counter for the WAIT state. Counts enabled cycles after a clear;
// tc is high on the enabled cycle that brings the count to TIMEOUT, so the
// FSM leaves WAIT after exactly TIMEOUT stalled cycles.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   clr        : synchronous clear (asserted the cycle before WAIT is entered)
//   en         : count this cycle
//   tc         : terminal count reached on this enabled cycle
module cordic_wdt_counter #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = en && (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/cordic_client_ctrl.sv
// cordic_client_ctrl
// Requester side of the CORDIC start/ready/ACK handshake. Takes an operand
// from an upstream valid/ready stream, pulses cordic_beg, waits for
// cordic_ready, captures the result, pulses cordic_ack and offers the result
// on a downstream valid/ready stream. Handshake outputs are Moore decodes of
// the registered state.
// Build option: CORDIC_TIMEOUT_EN adds a WAIT watchdog (TIMEOUT cycles) and
// a sticky timeout_err flag; without it timeout_err is tied to 0.
// Ports:
//   clk, reset                      : clock, asynchronous active-high reset
//   in_valid/in_ready/in_angle/in_op: upstream operand stream
//   cordic_angle/cordic_op          : registered operand to the CORDIC
//   cordic_beg/cordic_ack           : start and result-taken pulses
//   cordic_ready/cordic_data        : CORDIC result level and data
//   out_valid/out_ready/out_data    : downstream result stream
//   busy                            : FSM not in IDLE
//   timeout_err                     : sticky watchdog abort flag
module cordic_client_ctrl
    import cordic_client_pkg::*;
#(
    parameter int W       = W_DEFAULT,
    parameter int TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_angle,
    input  logic         in_op,
    output logic [W-1:0] cordic_angle,
    output logic         cordic_op,
    output logic         cordic_beg,
    input  logic         cordic_ready,
    input  logic [W-1:0] cordic_data,
    output logic         cordic_ack,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         busy,
    output logic         timeout_err
);

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("cordic_client_ctrl: TIMEOUT must be at least 1");
    end

    state_e       state_q, state_d;
    logic [W-1:0] cordic_angle_q, cordic_angle_d;
    logic         cordic_op_q, cordic_op_d;
    logic [W-1:0] out_data_q, out_data_d;
    logic         out_valid_q, out_valid_d;
    logic         accept, capture, wdt_expire;

    assign accept  = (state_q == S_IDLE) && in_valid;
    // A still-unread result blocks capture; the CORDIC keeps ready and data
    // stable until ACK, so holding off here loses nothing.
    assign capture = (state_q == S_WAIT) && cordic_ready && !out_valid_q;

`ifdef CORDIC_TIMEOUT_EN
    logic timeout_err_q, timeout_err_d;

    cordic_wdt_counter #(.TIMEOUT(TIMEOUT)) u_wdt (
        .clk   (clk),
        .reset (reset),
        .clr   (state_q == S_START),
        .en    ((state_q == S_WAIT) && !cordic_ready),
        .tc    (wdt_expire)
    );

    always_comb begin
        timeout_err_d = timeout_err_q;
        if (accept) begin
            timeout_err_d = 1'b0;
        end else if (wdt_expire) begin
            timeout_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timeout_err_q <= 1'b0;
        end else begin
            timeout_err_q <= timeout_err_d;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    assign wdt_expire  = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (in_valid) state_d = S_START;
            S_START: state_d = S_WAIT;
            S_WAIT: begin
                if (capture) begin
                    state_d = S_ACK;
                end else if (wdt_expire) begin
                    state_d = S_IDLE;
                end
            end
            S_ACK:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cordic_angle_d = cordic_angle_q;
        cordic_op_d    = cordic_op_q;
        out_data_d     = out_data_q;
        out_valid_d    = out_valid_q;
        if (accept) begin
            cordic_angle_d = in_angle;
            cordic_op_d    = in_op;
        end
        // Downstream drain is state-independent; a capture on the same edge
        // overrides it.
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        if (capture) begin
            out_data_d  = cordic_data;
            out_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            cordic_angle_q <= '0;
            cordic_op_q    <= 1'b0;
            out_data_q     <= '0;
            out_valid_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            cordic_angle_q <= cordic_angle_d;
            cordic_op_q    <= cordic_op_d;
            out_data_q     <= out_data_d;
            out_valid_q    <= out_valid_d;
        end
    end

    assign in_ready     = (state_q == S_IDLE);
    assign cordic_beg   = (state_q == S_START);
    assign cordic_ack   = (state_q == S_ACK);
    assign busy         = (state_q != S_IDLE);
    assign cordic_angle = cordic_angle_q;
    assign cordic_op    = cordic_op_q;
    assign out_data     = out_data_q;
    assign out_valid    = out_valid_q;

endmodule
